dmem_access_unit: RTL and testbench

DMEM_ACCESS_UNIT -- requirements
Module: dmem_access_unit

---
 rtl/dmem_access_unit.sv | 177 +++++++++++++++++
 tb/tb_dmem_access_unit.sv | 522 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: MEM-stage load/store sequencer for a single-beat bus
// with lane alignment, load extension and an ack timeout.
module dmem_access_unit #(
  parameter int XLEN   = 32,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TMO    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [XLEN-1:0]       wdata,
  output logic                  stall,
  output logic                  done,
  output logic                  err,
  output logic [XLEN-1:0]       rdata,
  output logic                  m_req,
  output logic                  m_we,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W/8-1:0]   m_wstrb,
  output logic [DATA_W-1:0]     m_wdata,
  input  logic                  m_ack,
  input  logic [DATA_W-1:0]     m_rdata
);

  localparam int NB = DATA_W / 8;
  localparam int LW = $clog2(NB);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t            state;
  logic              live;
  logic [2:0]        f3;
  logic [LW-1:0]     lane;
  logic [7:0]        cnt;
  logic [7:0]        cnt_nxt;
  logic              start;
  logic              ok;
  logic [LW-1:0]     lane_in;
  logic [NB-1:0]     strb_in;
  logic [DATA_W-1:0] wd_in;
  logic [XLEN-1:0]   sh;
  logic [XLEN-1:0]   ld;

  assign start   = mem_read | mem_write;
  assign lane_in = addr[LW-1:0];
  assign cnt_nxt = cnt + 8'd1;
  assign sh      = XLEN'(m_rdata >> {lane, 3'b000});

  // live holds outputs at reset values until the first edge after release
  assign stall = (state == BUSY) ||
                 ((state == IDLE) && start && live);

  always_comb begin
    ok = 1'b0;
    if (mem_read && !mem_write)
      ok = funct3 inside {3'b000, 3'b001, 3'b010,
                          3'b100, 3'b101};
    else if (mem_write && !mem_read)
      ok = funct3 inside {3'b000, 3'b001, 3'b010};
    if (funct3[1:0] == 2'b01 && addr[0])
      ok = 1'b0;
    if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)
      ok = 1'b0;
  end

  always_comb begin
    strb_in = '0;
    wd_in   = '0;
    unique case (1'b1)
      funct3[1:0] == 2'b00: begin
        strb_in = NB'(1);
        wd_in   = DATA_W'(wdata[7:0]);
      end
      funct3[1:0] == 2'b01: begin
        strb_in = NB'(3);
        wd_in   = DATA_W'(wdata[15:0]);
      end
      default: begin
        strb_in = NB'(15);
        wd_in   = DATA_W'(wdata);
      end
    endcase
  end

  always_comb begin
    ld = sh;
    unique case (1'b1)
      f3 == 3'b000: ld = {{(XLEN-8){sh[7]}}, sh[7:0]};
      f3 == 3'b001: ld = {{(XLEN-16){sh[15]}}, sh[15:0]};
      f3 == 3'b100: ld = {{(XLEN-8){1'b0}}, sh[7:0]};
      f3 == 3'b101: ld = {{(XLEN-16){1'b0}}, sh[15:0]};
      default:      ld = sh;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      live    <= 1'b0;
      f3      <= '0;
      lane    <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wstrb <= '0;
      m_wdata <= '0;
    end else begin
      live <= 1'b1;
      unique case (state)
        IDLE: begin
          if (start && live) begin
            f3      <= funct3;
            lane    <= lane_in;
            cnt     <= '0;
            m_addr  <= addr & ~ADDR_W'(NB - 1);
            m_we    <= ok && mem_write;
            m_wstrb <= (ok && mem_write) ?
                       (strb_in << lane_in) : '0;
            m_wdata <= wd_in << {lane_in, 3'b000};
            if (ok) begin
              state <= BUSY;
              m_req <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
              rdata <= '0;
            end
          end
        end
        BUSY: begin
          // ack beats the timeout on the same cycle
          if (m_ack) begin
            state   <= DONE;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_wstrb <= '0;
            done    <= 1'b1;
            err     <= 1'b0;
            rdata   <= m_we ? '0 : ld;
          end else if (cnt_nxt == 8'(TMO)) begin
            state   <= DONE;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_wstrb <= '0;
            done    <= 1'b1;
            err     <= 1'b1;
            rdata   <= '0;
            cnt     <= cnt_nxt;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          err   <= 1'b0;
          rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed scenarios on three configurations
// (32-bit bus, short timeout, 64-bit bus).
module tb_dmem_access_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mem_read = 1'b0;
  logic mem_write = 1'b0;
  logic [2:0] funct3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;

  logic stall_a, done_a, err_a, m_req_a, m_we_a;
  logic m_ack_a = 1'b0;
  logic [31:0] rdata_a, m_addr_a, m_wdata_a;
  logic [31:0] m_rdata_a = '0;
  logic [3:0] m_wstrb_a;

  logic stall_t, done_t, err_t, m_req_t, m_we_t;
  logic m_ack_t = 1'b0;
  logic [31:0] rdata_t, m_addr_t, m_wdata_t;
  logic [31:0] m_rdata_t = '0;
  logic [3:0] m_wstrb_t;

  logic stall_w, done_w, err_w, m_req_w, m_we_w;
  logic m_ack_w = 1'b0;
  logic [31:0] rdata_w, m_addr_w;
  logic [63:0] m_wdata_w;
  logic [63:0] m_rdata_w = '0;
  logic [7:0] m_wstrb_w;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dmem_access_unit u_a (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata),
    .stall(stall_a), .done(done_a), .err(err_a),
    .rdata(rdata_a), .m_req(m_req_a), .m_we(m_we_a),
    .m_addr(m_addr_a), .m_wstrb(m_wstrb_a),
    .m_wdata(m_wdata_a), .m_ack(m_ack_a),
    .m_rdata(m_rdata_a)
  );

  dmem_access_unit #(.TMO(4)) u_t (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata),
    .stall(stall_t), .done(done_t), .err(err_t),
    .rdata(rdata_t), .m_req(m_req_t), .m_we(m_we_t),
    .m_addr(m_addr_t), .m_wstrb(m_wstrb_t),
    .m_wdata(m_wdata_t), .m_ack(m_ack_t),
    .m_rdata(m_rdata_t)
  );

  dmem_access_unit #(.DATA_W(64)) u_w (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata),
    .stall(stall_w), .done(done_w), .err(err_w),
    .rdata(rdata_w), .m_req(m_req_w), .m_we(m_we_w),
    .m_addr(m_addr_w), .m_wstrb(m_wstrb_w),
    .m_wdata(m_wdata_w), .m_ack(m_ack_w),
    .m_rdata(m_rdata_w)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    m_ack_a = 1'b0;
    m_ack_t = 1'b0;
    m_ack_w = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset;
    rst = 1'b0;
    mem_read = 1'b1;
    funct3 = 3'b010;
    addr = 32'h4000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({stall_a, done_a, err_a, m_req_a, m_we_a} !== 5'b0) begin
      bad++;
      $display("FAIL rst_ctrl got=%b exp=00000",
               {stall_a, done_a, err_a, m_req_a, m_we_a});
    end
    total++;
    if (m_wstrb_a !== 4'h0) begin
      bad++;
      $display("FAIL rst_wstrb got=%h exp=0", m_wstrb_a);
    end
    total++;
    if ({m_addr_a, m_wdata_a, rdata_a} !== 96'h0) begin
      bad++;
      $display("FAIL rst_data got=%h/%h/%h exp=0",
               m_addr_a, m_wdata_a, rdata_a);
    end
    mem_read = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if ({stall_a, done_a, m_req_a} !== 3'b0) begin
      bad++;
      $display("FAIL rst_release got=%b exp=000",
               {stall_a, done_a, m_req_a});
    end
    step();
  endtask

  task automatic test_ack_ignored;
    do_reset();
    m_ack_a = 1'b1;
    @(negedge clk);
    step();
    m_ack_a = 1'b0;
    @(negedge clk);
    total++;
    if ({done_a, m_req_a, stall_a} !== 3'b0) begin
      bad++;
      $display("FAIL ack_idle got=%b exp=000",
               {done_a, m_req_a, stall_a});
    end
    step();
  endtask

  task automatic test_lb;
    int stalls;
    int busy;
    bit got;
    stalls = 0;
    busy = 0;
    got = 1'b0;
    do_reset();
    mem_read = 1'b1;
    funct3 = 3'b000;
    addr = 32'h1003;
    m_rdata_a = 32'h80FF_FF12;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (stall_a) stalls++;
      if (done_a) begin
        got = 1'b1;
        total++;
        if (rdata_a !== 32'hFFFF_FF80) begin
          bad++;
          $display("FAIL lb_rdata got=%h exp=ffffff80", rdata_a);
        end
        total++;
        if (err_a !== 1'b0) begin
          bad++;
          $display("FAIL lb_err got=%b exp=0", err_a);
        end
        mem_read = 1'b0;
      end else if (m_req_a) begin
        busy++;
        if (busy == 1) begin
          total++;
          if ({m_addr_a, m_wstrb_a, m_we_a} !== {32'h1000, 4'h0, 1'b0}) begin
            bad++;
            $display("FAIL lb_bus got=%h/%h/%b exp=1000/0/0",
                     m_addr_a, m_wstrb_a, m_we_a);
          end
        end
        m_ack_a = (busy == 4);
      end
      step();
      m_ack_a = 1'b0;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL lb_done got=none exp=done within 20 cycles");
    end
    total++;
    if (stalls != 5) begin
      bad++;
      $display("FAIL lb_stall got=%0d exp=5", stalls);
    end
    total++;
    if (busy != 4) begin
      bad++;
      $display("FAIL lb_req_cycles got=%0d exp=4", busy);
    end
    @(negedge clk);
    total++;
    if (done_a !== 1'b0) begin
      bad++;
      $display("FAIL lb_pulse got=%b exp=0", done_a);
    end
    step();
  endtask

  task automatic test_sh;
    do_reset();
    mem_write = 1'b1;
    funct3 = 3'b001;
    addr = 32'h2002;
    wdata = 32'h0000_ABCD;
    @(negedge clk);
    total++;
    if (stall_a !== 1'b1) begin
      bad++;
      $display("FAIL sh_stall0 got=%b exp=1", stall_a);
    end
    step();
    @(negedge clk);
    total++;
    if ({m_req_a, m_we_a, m_wstrb_a} !== {1'b1, 1'b1, 4'b1100}) begin
      bad++;
      $display("FAIL sh_ctrl got=%b/%b/%b exp=1/1/1100",
               m_req_a, m_we_a, m_wstrb_a);
    end
    total++;
    if ({m_addr_a, m_wdata_a} !== {32'h2000, 32'hABCD_0000}) begin
      bad++;
      $display("FAIL sh_bus got=%h/%h exp=2000/abcd0000",
               m_addr_a, m_wdata_a);
    end
    m_ack_a = 1'b1;
    step();
    m_ack_a = 1'b0;
    @(negedge clk);
    total++;
    if ({done_a, err_a, stall_a, rdata_a} !== {3'b100, 32'h0}) begin
      bad++;
      $display("FAIL sh_done got=%b%b%b/%h exp=100/0",
               done_a, err_a, stall_a, rdata_a);
    end
    mem_write = 1'b0;
    step();
    @(negedge clk);
    total++;
    if (done_a !== 1'b0) begin
      bad++;
      $display("FAIL sh_pulse got=%b exp=0", done_a);
    end
    step();
  endtask

  task automatic test_illegal;
    logic ir [6];
    logic iw [6];
    logic [2:0] if3 [6];
    logic [31:0] ia [6];
    ir  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    iw  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    if3 = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b011, 3'b001};
    ia  = '{32'h3001, 32'h3000, 32'h3000,
            32'h3001, 32'h3000, 32'h3003};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      mem_read = ir[i];
      mem_write = iw[i];
      funct3 = if3[i];
      addr = ia[i];
      @(negedge clk);
      total++;
      if (stall_a !== 1'b1) begin
        bad++;
        $display("FAIL ill%0d_stall got=%b exp=1", i, stall_a);
      end
      step();
      @(negedge clk);
      total++;
      if ({done_a, err_a, m_req_a, m_we_a, rdata_a} !==
          {4'b1100, 32'h0}) begin
        bad++;
        $display("FAIL ill%0d_done got=%b%b%b%b/%h exp=1100/0",
                 i, done_a, err_a, m_req_a, m_we_a, rdata_a);
      end
      mem_read = 1'b0;
      mem_write = 1'b0;
      step();
    end
  endtask

  task automatic test_timeout;
    int busy;
    bit got;
    logic exp_err;
    logic [31:0] exp_rd;
    for (int r = 0; r < 2; r++) begin
      busy = 0;
      got = 1'b0;
      exp_err = (r == 0);
      exp_rd = (r == 0) ? 32'h0 : 32'h1234_5678;
      do_reset();
      mem_read = 1'b1;
      funct3 = 3'b010;
      addr = 32'h4000;
      m_rdata_t = 32'h1234_5678;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge clk);
        if (done_t) begin
          got = 1'b1;
          total++;
          if ({err_t, m_req_t} !== {exp_err, 1'b0}) begin
            bad++;
            $display("FAIL tmo%0d_err got=%b/%b exp=%b/0",
                     r, err_t, m_req_t, exp_err);
          end
          total++;
          if (rdata_t !== exp_rd) begin
            bad++;
            $display("FAIL tmo%0d_rdata got=%h exp=%h",
                     r, rdata_t, exp_rd);
          end
          mem_read = 1'b0;
        end else if (m_req_t) begin
          busy++;
          m_ack_t = (r == 1) && (busy == 4);
        end
        step();
        m_ack_t = 1'b0;
      end
      total++;
      if (!got) begin
        bad++;
        $display("FAIL tmo%0d_done got=none exp=done", r);
      end
      total++;
      if (busy != 4) begin
        bad++;
        $display("FAIL tmo%0d_req_cycles got=%0d exp=4", r, busy);
      end
    end
  endtask

  task automatic test_wide;
    do_reset();
    mem_read = 1'b1;
    funct3 = 3'b101;
    addr = 32'h5006;
    m_rdata_w = 64'hBEEF_0000_0000_0000;
    @(negedge clk);
    step();
    @(negedge clk);
    total++;
    if ({m_req_w, m_addr_w, m_wstrb_w} !== {1'b1, 32'h5000, 8'h00}) begin
      bad++;
      $display("FAIL w_lhu_bus got=%b/%h/%h exp=1/5000/00",
               m_req_w, m_addr_w, m_wstrb_w);
    end
    m_ack_w = 1'b1;
    step();
    m_ack_w = 1'b0;
    @(negedge clk);
    total++;
    if ({done_w, err_w, rdata_w} !== {2'b10, 32'h0000_BEEF}) begin
      bad++;
      $display("FAIL w_lhu_done got=%b%b/%h exp=10/0000beef",
               done_w, err_w, rdata_w);
    end
    mem_read = 1'b0;
    step();
    mem_write = 1'b1;
    funct3 = 3'b000;
    addr = 32'h5005;
    wdata = 32'h1234_565A;
    @(negedge clk);
    step();
    @(negedge clk);
    total++;
    if ({m_we_w, m_addr_w, m_wstrb_w} !== {1'b1, 32'h5000, 8'h20}) begin
      bad++;
      $display("FAIL w_sb_ctrl got=%b/%h/%h exp=1/5000/20",
               m_we_w, m_addr_w, m_wstrb_w);
    end
    total++;
    if (m_wdata_w !== 64'h0000_5A00_0000_0000) begin
      bad++;
      $display("FAIL w_sb_wdata got=%h exp=00005a0000000000",
               m_wdata_w);
    end
    m_ack_w = 1'b1;
    step();
    m_ack_w = 1'b0;
    @(negedge clk);
    total++;
    if ({done_w, err_w, rdata_w} !== {2'b10, 32'h0}) begin
      bad++;
      $display("FAIL w_sb_done got=%b%b/%h exp=10/0",
               done_w, err_w, rdata_w);
    end
    mem_write = 1'b0;
    step();
  endtask

  task automatic test_back_to_back;
    logic [2:0] tf3 [5];
    logic [31:0] ta [5];
    logic [31:0] trd [5];
    logic [31:0] te [5];
    tf3 = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b010};
    ta  = '{32'h1000, 32'h1002, 32'h1001, 32'h1000, 32'h1004};
    trd = '{32'h0000_007F, 32'h8001_0000, 32'h0000_F000,
            32'h0000_FFFF, 32'hDEAD_BEEF};
    te  = '{32'h0000_007F, 32'hFFFF_8001, 32'h0000_00F0,
            32'h0000_FFFF, 32'hDEAD_BEEF};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      mem_read = 1'b1;
      funct3 = tf3[i];
      addr = ta[i];
      m_rdata_a = trd[i];
      @(negedge clk);
      total++;
      if ({stall_a, m_req_a} !== 2'b10) begin
        bad++;
        $display("FAIL b2b%0d_idle got=%b%b exp=10",
                 i, stall_a, m_req_a);
      end
      step();
      @(negedge clk);
      total++;
      if ({m_req_a, m_addr_a} !== {1'b1, ta[i] & 32'hFFFF_FFFC}) begin
        bad++;
        $display("FAIL b2b%0d_bus got=%b/%h exp=1/%h",
                 i, m_req_a, m_addr_a, ta[i] & 32'hFFFF_FFFC);
      end
      m_ack_a = 1'b1;
      step();
      m_ack_a = 1'b0;
      @(negedge clk);
      total++;
      if ({done_a, err_a, stall_a, rdata_a} !== {3'b100, te[i]}) begin
        bad++;
        $display("FAIL b2b%0d_done got=%b%b%b/%h exp=100/%h",
                 i, done_a, err_a, stall_a, rdata_a, te[i]);
      end
      step();
    end
    mem_read = 1'b0;
    step();
  endtask

  task automatic test_reset_busy;
    do_reset();
    mem_read = 1'b1;
    funct3 = 3'b010;
    addr = 32'h4000;
    step();
    @(negedge clk);
    total++;
    if (m_req_a !== 1'b1) begin
      bad++;
      $display("FAIL rb_busy got=%b exp=1", m_req_a);
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if ({m_req_a, stall_a, done_a} !== 3'b000) begin
      bad++;
      $display("FAIL rb_async got=%b%b%b exp=000",
               m_req_a, stall_a, done_a);
    end
    mem_read = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
    mem_read = 1'b1;
    addr = 32'h6000;
    m_rdata_a = 32'hCAFE_F00D;
    @(negedge clk);
    step();
    @(negedge clk);
    total++;
    if ({m_req_a, m_addr_a} !== {1'b1, 32'h6000}) begin
      bad++;
      $display("FAIL rb_req got=%b/%h exp=1/6000", m_req_a, m_addr_a);
    end
    m_ack_a = 1'b1;
    step();
    m_ack_a = 1'b0;
    @(negedge clk);
    total++;
    if ({done_a, err_a, rdata_a} !== {2'b10, 32'hCAFE_F00D}) begin
      bad++;
      $display("FAIL rb_done got=%b%b/%h exp=10/cafef00d",
               done_a, err_a, rdata_a);
    end
    mem_read = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_ack_ignored();
    test_lb();
    test_sh();
    test_illegal();
    test_timeout();
    test_wide();
    test_back_to_back();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
